// File: rtl/barrel_shift_arbiter.sv
// Round-robin arbiter sharing one external combinational barrel shifter between requesters A and B.
// Flow: accept in IDLE, drive the shifter for one EXEC cycle, then hold the result in RESP until it is taken.
module barrel_shift_arbiter #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_req_valid,
    output logic             a_req_ready,
    input  logic [WIDTH-1:0] a_req_data,
    input  logic [SHW-1:0]   a_req_shamt,
    input  logic             a_req_lr,
    input  logic             a_req_al,
    output logic             a_rsp_valid,
    input  logic             a_rsp_ready,
    input  logic             b_req_valid,
    output logic             b_req_ready,
    input  logic [WIDTH-1:0] b_req_data,
    input  logic [SHW-1:0]   b_req_shamt,
    input  logic             b_req_lr,
    input  logic             b_req_al,
    output logic             b_rsp_valid,
    input  logic             b_rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] sh_din,
    output logic [SHW-1:0]   sh_shamt,
    output logic             sh_lr,
    output logic             sh_al,
    input  logic [WIDTH-1:0] sh_dout,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e           state_q, state_d;
    logic             prio_q, prio_d;     // 0 = A preferred, 1 = B preferred
    logic             owner_q, owner_d;   // 0 = A, 1 = B
    logic [WIDTH-1:0] sh_din_q, sh_din_d;
    logic [SHW-1:0]   sh_shamt_q, sh_shamt_d;
    logic             sh_lr_q, sh_lr_d;
    logic             sh_al_q, sh_al_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             a_win, b_win;

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        owner_d    = owner_q;
        sh_din_d   = sh_din_q;
        sh_shamt_d = sh_shamt_q;
        sh_lr_d    = sh_lr_q;
        sh_al_d    = sh_al_q;
        rsp_data_d = rsp_data_q;

        // prio only breaks ties; a lone requester always wins
        a_win = a_req_valid && (!b_req_valid || !prio_q);
        b_win = b_req_valid && (!a_req_valid ||  prio_q);

        case (state_q)
            IDLE: begin
                if (a_win || b_win) begin
                    owner_d    = b_win;
                    sh_din_d   = b_win ? b_req_data  : a_req_data;
                    sh_shamt_d = b_win ? b_req_shamt : a_req_shamt;
                    sh_lr_d    = b_win ? b_req_lr    : a_req_lr;
                    sh_al_d    = b_win ? b_req_al    : a_req_al;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d = sh_dout;
                state_d    = RESP;
            end
            RESP: begin
                if (owner_q ? b_rsp_ready : a_rsp_ready) begin
                    prio_d  = ~owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            owner_q    <= 1'b0;
            sh_din_q   <= '0;
            sh_shamt_q <= '0;
            sh_lr_q    <= 1'b0;
            sh_al_q    <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            owner_q    <= owner_d;
            sh_din_q   <= sh_din_d;
            sh_shamt_q <= sh_shamt_d;
            sh_lr_q    <= sh_lr_d;
            sh_al_q    <= sh_al_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign a_req_ready = (state_q == IDLE) && a_win;
    assign b_req_ready = (state_q == IDLE) && b_win;
    assign a_rsp_valid = (state_q == RESP) && !owner_q;
    assign b_rsp_valid = (state_q == RESP) &&  owner_q;
    assign rsp_data    = rsp_data_q;
    assign sh_din      = sh_din_q;
    assign sh_shamt    = sh_shamt_q;
    assign sh_lr       = sh_lr_q;
    assign sh_al       = sh_al_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Randomized bench for barrel_shift_arbiter: transaction-level model of arbitration and shift results,
// with a bit-level shifter standing in for the external datapath.
module tb_barrel_shift_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_req_valid, a_req_ready, a_req_lr, a_req_al, a_rsp_valid, a_rsp_ready;
    logic       b_req_valid, b_req_ready, b_req_lr, b_req_al, b_rsp_valid, b_rsp_ready;
    logic [7:0] a_req_data, b_req_data, rsp_data, sh_din, sh_dout;
    logic [2:0] a_req_shamt, b_req_shamt, sh_shamt;
    logic       sh_lr, sh_al, busy;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [2:0] s;
        logic       lr;
        logic       al;
    } req_t;

    req_t pend [2];
    logic prio;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    barrel_shift_arbiter #(.WIDTH(8), .SHW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_data(a_req_data),
        .a_req_shamt(a_req_shamt), .a_req_lr(a_req_lr), .a_req_al(a_req_al),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_data(b_req_data),
        .b_req_shamt(b_req_shamt), .b_req_lr(b_req_lr), .b_req_al(b_req_al),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
        .rsp_data(rsp_data), .sh_din(sh_din), .sh_shamt(sh_shamt), .sh_lr(sh_lr),
        .sh_al(sh_al), .sh_dout(sh_dout), .busy(busy)
    );

    // external shifter, bit by bit
    always_comb begin
        sh_dout = '0;
        for (int i = 0; i < 8; i++) begin
            if (!sh_lr)
                sh_dout[i] = (i >= int'(sh_shamt)) ? sh_din[i - int'(sh_shamt)] : 1'b0;
            else
                sh_dout[i] = (i + int'(sh_shamt) < 8) ? sh_din[i + int'(sh_shamt)] : (sh_al & sh_din[7]);
        end
    end

    function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] s,
                                             input logic lr, input logic al);
        int v;
        if (!lr)
            v = (int'(d) * (1 << s)) % 256;
        else if (al && d[7])
            v = ((int'(d) - 256) >>> s) & 255;
        else
            v = int'(d) / (1 << s);
        return v[7:0];
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        r.v  = 1'b1;
        r.d  = 8'($urandom);
        r.s  = 3'($urandom);
        r.lr = 1'($urandom);
        r.al = 1'($urandom);
        return r;
    endfunction

    function automatic req_t mk(input logic [7:0] d, input logic [2:0] s, input logic lr, input logic al);
        req_t r;
        r.v = 1'b1; r.d = d; r.s = s; r.lr = lr; r.al = al;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        a_req_valid = pend[0].v; a_req_data = pend[0].d; a_req_shamt = pend[0].s;
        a_req_lr    = pend[0].lr; a_req_al  = pend[0].al;
        b_req_valid = pend[1].v; b_req_data = pend[1].d; b_req_shamt = pend[1].s;
        b_req_lr    = pend[1].lr; b_req_al  = pend[1].al;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full transaction starting from IDLE at a negedge; ends at the negedge after the handshake.
    task automatic run_txn(input int stall, input bit reissue);
        logic       w;
        logic [7:0] e;
        req_t       cur;
        a_rsp_ready = 1'b0;
        b_rsp_ready = 1'b0;
        drive();
        #1;
        w = (pend[0].v && pend[1].v) ? prio : pend[1].v;
        chk("idle_a_req_ready", a_req_ready, !w);
        chk("idle_b_req_ready", b_req_ready, w);
        chk("idle_busy", busy, 0);
        cur = pend[w];
        e   = ref_shift(cur.d, cur.s, cur.lr, cur.al);
        next_cycle();

        pend[w].v = 1'b0;
        if (reissue && $urandom_range(0, 1) == 1) pend[w] = rnd_req();
        drive();
        #1;
        chk("exec_busy", busy, 1);
        chk("exec_req_ready", {a_req_ready, b_req_ready}, 0);
        chk("exec_rsp_valid", {a_rsp_valid, b_rsp_valid}, 0);
        chk("exec_sh_din", sh_din, cur.d);
        chk("exec_sh_shamt", sh_shamt, cur.s);
        chk("exec_sh_lr", sh_lr, cur.lr);
        chk("exec_sh_al", sh_al, cur.al);
        next_cycle();

        for (int k = 0; k <= stall; k++) begin
            if (w) begin
                b_rsp_ready = (k == stall);
                a_rsp_ready = 1'($urandom);
            end else begin
                a_rsp_ready = (k == stall);
                b_rsp_ready = 1'($urandom);
            end
            #1;
            chk("resp_a_rsp_valid", a_rsp_valid, !w);
            chk("resp_b_rsp_valid", b_rsp_valid, w);
            chk("resp_rsp_data", rsp_data, e);
            chk("resp_busy", busy, 1);
            chk("resp_req_ready", {a_req_ready, b_req_ready}, 0);
            next_cycle();
        end
        prio = !w;
        a_rsp_ready = 1'b0;
        b_rsp_ready = 1'b0;
    endtask

    initial begin
        pend[0] = '{v: 1'b0, d: 8'h0, s: 3'h0, lr: 1'b0, al: 1'b0};
        pend[1] = pend[0];
        prio = 1'b0;
        rst_n = 1'b0;
        a_rsp_ready = 1'b0;
        b_rsp_ready = 1'b0;
        drive();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", {a_rsp_valid, b_rsp_valid}, 0);
        chk("rst_req_ready", {a_req_ready, b_req_ready}, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_sh", {sh_din, sh_shamt, sh_lr, sh_al}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // both valid after reset: A first, then B, then A wins the next tie
        pend[0] = mk(8'h96, 3'd2, 1'b0, 1'b0);
        pend[1] = mk(8'h80, 3'd3, 1'b1, 1'b1);
        run_txn(0, 0);
        run_txn(0, 0);
        pend[0] = mk(8'h3C, 3'd0, 1'b1, 1'b1);
        pend[1] = mk(8'h80, 3'd3, 1'b1, 1'b0);
        run_txn(0, 0);
        run_txn(0, 0);
        // long stall with the other requester waiting
        pend[0] = rnd_req();
        pend[1] = rnd_req();
        run_txn(5, 0);
        run_txn(0, 0);

        for (int i = 0; i < 150; i++) begin
            if (!pend[0].v && $urandom_range(0, 1) == 1) pend[0] = rnd_req();
            if (!pend[1].v && $urandom_range(0, 1) == 1) pend[1] = rnd_req();
            if (!pend[0].v && !pend[1].v) begin
                drive();
                #1;
                chk("noreq_req_ready", {a_req_ready, b_req_ready}, 0);
                chk("noreq_busy", busy, 0);
                next_cycle();
                pend[$urandom_range(0, 1)] = rnd_req();
            end
            run_txn($urandom_range(0, 3), 1);
        end

        // reset during EXEC: drop the command, then A wins the first tie
        pend[0].v = 1'b0;
        pend[1].v = 1'b0;
        pend[1] = rnd_req();
        run_txn(0, 0);
        pend[0] = rnd_req();
        pend[1].v = 1'b0;
        drive();
        next_cycle();
        pend[0].v = 1'b0;
        drive();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_rsp_valid", {a_rsp_valid, b_rsp_valid}, 0);
        chk("midrst_rsp_data", rsp_data, 0);
        chk("midrst_sh", {sh_din, sh_shamt, sh_lr, sh_al}, 0);
        chk("midrst_req_ready", {a_req_ready, b_req_ready}, 0);
        next_cycle();
        rst_n = 1'b1;
        prio = 1'b0;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            chk("postrst_rsp_valid", {a_rsp_valid, b_rsp_valid}, 0);
            chk("postrst_busy", busy, 0);
        end
        pend[0] = rnd_req();
        pend[1] = rnd_req();
        run_txn(1, 0);
        run_txn(0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
